sp_ram_arbiter: RTL and testbench
=================================

Name: sp_ram_arbiter

Overview:
- Shares one single-port data RAM (sp_ram) between NUM_MASTERS requesters, e.g. instruction fetch, LSU and debug/loader port.
- Uses a req/gnt/rvalid handshake with one access per cycle and fair round-robin arbitration.
- Drives the RAM's en/we/be/addr/wdata pins and routes the registered read data back to the master that owns it.
- Sits between the core/bus-side masters and the RAM instance.

Parameters:
- NUM_MASTERS, 3, number of requesting ports (2..8).
- ADDR_WIDTH, 32, width of the master-side byte address.
- RAM_ADDR_WIDTH, 20, width of the RAM-side byte address forwarded to sp_ram.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 wide.
- BASE_ADDR, 32'h0010_0000, global byte address of RAM word 0.
- RAM_BYTES, 32'h0001_0000, size of the RAM window in bytes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous and active-low.
- req_i  in  NUM_MASTERS  per-master request.
- addr_i  in  NUM_MASTERS x ADDR_WIDTH  per-master global byte address.
- we_i  in  NUM_MASTERS  per-master write enable.
- be_i  in  NUM_MASTERS x DATA_WIDTH/8  per-master byte enables.
- wdata_i  in  NUM_MASTERS x DATA_WIDTH  per-master write data.
- gnt_o  out  NUM_MASTERS  one-hot grant, combinational from req_i.
- rvalid_o  out  NUM_MASTERS  one-hot response valid.
- rdata_o  out  DATA_WIDTH  read data, shared by all masters and qualified by rvalid_o.
- err_o  out  NUM_MASTERS  error response (driven only under the macro; otherwise tied to 0).
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
- ram_addr_o  out  RAM_ADDR_WIDTH  addr_i[RAM_ADDR_WIDTH-1:0] of the granted master.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o.

Behaviour:
- Arbitration
  - Round-robin. Register last_q holds the index of the last granted master; its reset value is NUM_MASTERS-1, so master 0 wins first.
  - Each cycle the winner is the first requesting master at or after last_q+1, taken modulo NUM_MASTERS.
  - gnt_o is one-hot (or all zero) in the same cycle as req_i.
  - last_q updates to the winner only on a cycle with a grant; idle cycles leave it unchanged.
- A transaction is accepted when req_i & gnt_o; the master may change its request the next cycle.
  - Back-to-back grants (one per cycle) are allowed, to the same or different masters.
- RAM drive
  - ram_en_o = |gnt_o. ram_we_o, ram_be_o, ram_addr_o and ram_wdata_o are muxed from the winner.
  - When nothing is granted: ram_we_o=0, ram_be_o=0, and addr/wdata are don't-care (hold the master-0 mux value).
- Response pipeline
  - Registers rvalid_q (one-hot, NUM_MASTERS bits) and err_q capture the grant vector at the clock edge.
  - rvalid_o = rvalid_q, and rdata_o = ram_rdata_i, in the cycle after the grant. Latency is exactly 1 cycle for reads and writes.
  - Writes also produce rvalid; rdata is undefined for writes.
- A master with req_i held high across cycles receives a grant in at most NUM_MASTERS cycles (no starvation).
- Reset values, asynchronous on rst_n low:
  - last_q = NUM_MASTERS-1, rvalid_q = 0, err_q = 0.
  - Consequently gnt_o depends only on req_i; rvalid_o = 0 and err_o = 0.
  - A response pending at reset is dropped and never delivered.
- Simultaneous events:
  - A grant and the response to the previous grant coexist in the same cycle.
  - A same-master read-after-write to the same address on consecutive cycles returns the new data, because the RAM updates on the write edge.

Optional Feature:
- Macro: SP_RAM_ARB_RANGE_CHECK_EN.
- With the macro defined:
  - A request whose addr_i is outside [BASE_ADDR, BASE_ADDR+RAM_BYTES) is still granted, but ram_en_o and ram_we_o stay 0 for it.
  - The response cycle asserts rvalid_o and err_o together for that master; rdata_o is don't-care.
  - In-range requests behave normally with err_o=0.
- Without the macro: no decode is done. err_o is tied to 0 and every grant drives ram_en_o.

Decomposition:
- Package sp_ram_arb_pkg holds:
  - localparam defaults: NUM_MASTERS_DEF, BASE_ADDR_DEF, RAM_BYTES_DEF.
  - typedef of the per-master request struct: addr, we, be, wdata.
  - function rr_pick(req, last) returning the one-hot winner.
- Sub-module rr_arbiter contains the round-robin pointer register and the winner logic (req/last to gnt/idx). It is reusable by other shared scratchpads.

Test Plan:
- Reset, then master1 reads 0x0010_0008 with no other requests → gnt_o=3'b010 same cycle; ram_addr_o=0x00008; next cycle rvalid_o=3'b010 and rdata_o equals the RAM content.
- Masters 0, 1 and 2 all hold req for 6 cycles after reset → grants in the order 0,1,2,0,1,2; rvalid follows each grant by exactly 1 cycle.
- Master0 writes 0xDEADBEEF with be=4'b0011 to 0x0010_0010, then reads it on the next cycle → read returns lower half 0xBEEF merged with prior upper bytes.
- Master2 issues a request, then rst_n is pulsed low mid-cycle before the response edge → rvalid_o stays 0 and, after release, the first grant goes to master 0.
- With SP_RAM_ARB_RANGE_CHECK_EN, master1 reads 0x0020_0000 → gnt_o=3'b010, ram_en_o=0; next cycle rvalid_o[1]=1 and err_o[1]=1.
- Master0 holds req continuously while master1 requests once → master1 is granted within 2 cycles; last_q is unchanged on idle cycles.

Source files
------------

// File: rtl/sp_ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sp_ram_arb_pkg
// Shared definitions for the single-port RAM arbiter:
//   - default parameter values for the arbiter and its bus interface
//   - mst_req_t: per-master request payload (addr, we, be, wdata)
//   - rr_pick(): round-robin winner selection, returns a one-hot grant
// ---------------------------------------------------------------------------
package sp_ram_arb_pkg;

    localparam int unsigned MAX_MASTERS        = 8;
    localparam int unsigned MAX_IDX_W          = 3;

    localparam int unsigned NUM_MASTERS_DEF    = 3;
    localparam int unsigned ADDR_WIDTH_DEF     = 32;
    localparam int unsigned RAM_ADDR_WIDTH_DEF = 20;
    localparam int unsigned DATA_WIDTH_DEF     = 32;
    localparam int unsigned BE_WIDTH_DEF       = DATA_WIDTH_DEF / 8;

    localparam logic [ADDR_WIDTH_DEF-1:0] BASE_ADDR_DEF = 32'h0010_0000;
    localparam logic [ADDR_WIDTH_DEF-1:0] RAM_BYTES_DEF = 32'h0001_0000;

    // One master's request as seen on the shared bus (default widths).
    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic                      we;
        logic [BE_WIDTH_DEF-1:0]   be;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } mst_req_t;

    // First requester at or after last+1 (modulo n) wins; all-zero if idle.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [MAX_IDX_W-1:0]   last,
        input int unsigned            n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic                   found;
        int unsigned            idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= MAX_MASTERS; off++) begin
            if (off <= n) begin
                idx = (32'(last) + off) % n;
                if (!found && req[idx[MAX_IDX_W-1:0]]) begin
                    gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
                    found                   = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage : sp_ram_arb_pkg

// File: rtl/sp_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter_if
// Master-side bus of the shared scratchpad: per-master request vectors and
// the shared response path.
//   req_i/addr_i/we_i/be_i/wdata_i : per-master request (master -> arbiter)
//   gnt_o                          : one-hot grant, same cycle as req_i
//   rvalid_o/err_o                 : one-hot response, one cycle after grant
//   rdata_o                        : shared read data qualified by rvalid_o
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface sp_ram_arbiter_if #(
    parameter int unsigned NUM_MASTERS = sp_ram_arb_pkg::NUM_MASTERS_DEF,
    parameter int unsigned ADDR_WIDTH  = sp_ram_arb_pkg::ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = sp_ram_arb_pkg::DATA_WIDTH_DEF
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]                 req_i;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NUM_MASTERS-1:0]                 we_i;
    logic [NUM_MASTERS-1:0][BE_WIDTH-1:0]   be_i;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NUM_MASTERS-1:0]                 gnt_o;
    logic [NUM_MASTERS-1:0]                 rvalid_o;
    logic [DATA_WIDTH-1:0]                  rdata_o;
    logic [NUM_MASTERS-1:0]                 err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface : sp_ram_arbiter_if

// File: rtl/sp_ram_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered last-winner pointer. Reusable for any
// shared single-port resource.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   gnt_c      : one-hot grant, combinational from req
//   idx_c      : binary index of the winner (0 when nothing is granted)
// The pointer resets to NUM_MASTERS-1 so master 0 has first priority, and it
// only moves on cycles that actually grant.
// ---------------------------------------------------------------------------
module rr_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = NUM_MASTERS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MASTERS-1:0]         req,
    output logic [NUM_MASTERS-1:0]         gnt_c,
    output logic [$clog2(NUM_MASTERS)-1:0] idx_c
);
    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    logic [IDX_W-1:0]       last_q;
    logic [MAX_MASTERS-1:0] pick;
    logic                   unused_pick;

    // Winner selection and one-hot to index conversion.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        pick  = rr_pick(MAX_MASTERS'(req), MAX_IDX_W'(last_q), NUM_MASTERS);
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (pick[i]) begin
                gnt_c[i] = 1'b1;
                idx_c    = IDX_W'(i);
            end
        end
    end

    // Bits above NUM_MASTERS are never set by rr_pick.
    assign unused_pick = ^pick;

    // Pointer to the last granted master; holds on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(NUM_MASTERS - 1);
        end else if (|gnt_c) begin
            last_q <= idx_c;
        end
    end

endmodule : rr_arbiter

// File: rtl/sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter
// Shares one single-port data RAM between NUM_MASTERS requesters with a
// req/gnt/rvalid handshake, one access per cycle, round-robin fairness.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : master-side request/grant/response bus
//   ram_en_o       : RAM enable (any grant that reaches the RAM)
//   ram_we_o       : RAM write enable
//   ram_be_o       : RAM byte enables (zero when idle)
//   ram_addr_o     : low RAM_ADDR_WIDTH bits of the winner's byte address
//   ram_wdata_o    : winner's write data
//   ram_rdata_i    : RAM read data, valid the cycle after ram_en_o
// Response: rvalid_o is the grant vector delayed one cycle, rdata_o is the
// RAM output passed straight through during that cycle.
// Optional build macro SP_RAM_ARB_RANGE_CHECK_EN: requests outside
// [BASE_ADDR, BASE_ADDR+RAM_BYTES) are granted but kept off the RAM and
// answered with err_o; without it err_o is tied low.
// ---------------------------------------------------------------------------
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned           NUM_MASTERS    = NUM_MASTERS_DEF,
    parameter int unsigned           ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned           RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int unsigned           DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = BASE_ADDR_DEF,
    parameter logic [ADDR_WIDTH-1:0] RAM_BYTES      = RAM_BYTES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sp_ram_arbiter_if.slave           bus,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] gnt;
    logic [IDX_W-1:0]       win_idx;
    logic                   gnt_any;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic                   win_we;
    logic [BE_WIDTH-1:0]    win_be;
    logic [DATA_WIDTH-1:0]  win_wdata;
    logic                   in_range;
    logic                   acc_ok;
    logic [NUM_MASTERS-1:0] rvalid_q;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.req_i),
        .gnt_c (gnt),
        .idx_c (win_idx)
    );

    assign bus.gnt_o = gnt;
    assign gnt_any   = |gnt;

    // Winner mux; with no grant win_idx is 0, so master 0's fields show.
    always_comb begin
        win_addr  = bus.addr_i[win_idx];
        win_we    = bus.we_i[win_idx];
        win_be    = bus.be_i[win_idx];
        win_wdata = bus.wdata_i[win_idx];
    end

    // Window decode, one extra bit so BASE_ADDR+RAM_BYTES cannot wrap.
    assign in_range = ({1'b0, win_addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, win_addr} <  ({1'b0, BASE_ADDR} + {1'b0, RAM_BYTES}));

`ifdef SP_RAM_ARB_RANGE_CHECK_EN
    assign acc_ok = in_range;
`else
    logic unused_range;
    assign acc_ok       = 1'b1;
    assign unused_range = in_range;
`endif

    // RAM pin drive.
    always_comb begin
        ram_en_o    = gnt_any & acc_ok;
        ram_we_o    = gnt_any & acc_ok & win_we;
        ram_be_o    = gnt_any ? win_be : '0;
        ram_addr_o  = win_addr[RAM_ADDR_WIDTH-1:0];
        ram_wdata_o = win_wdata;
    end

    // Response valid: grant vector delayed by the RAM's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt;
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = ram_rdata_i;

`ifdef SP_RAM_ARB_RANGE_CHECK_EN
    logic [NUM_MASTERS-1:0] err_q;

    // Error flag travels with the response of a request that missed the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= gnt & {NUM_MASTERS{~acc_ok}};
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = '0;
`endif

endmodule : sp_ram_arbiter

// File: tb/tb_sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_arbiter
// Self-checking bench for sp_ram_arbiter: directed scenarios followed by
// random traffic. A reference model predicts grants, RAM pin values and the
// response of every accepted request; responses are queued and compared by
// an independent monitor. A behavioural single-port RAM sits on the RAM pins.
// ---------------------------------------------------------------------------
module tb_sp_ram_arbiter;
    import sp_ram_arb_pkg::*;

    localparam int unsigned N     = NUM_MASTERS_DEF;
    localparam int unsigned WORDS = 16384;

`ifdef SP_RAM_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        int unsigned    due;
        logic [N-1:0]   onehot;
        logic           we;
        logic           err;
        logic [31:0]    rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    sp_ram_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sp_ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int          m_last;
    exp_t        sb[$];
    exp_t        mon_e;
    mst_req_t    stim [N];
    logic [31:0] ram_mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic        mem_init_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int unsigned i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Behavioural single-port RAM: write-on-edge, registered read.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(WORDS); i++) ram_mem[i] <= init_word(32'(i));
            mem_init_done <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[15:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr[15:2]];
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Rule: first requester at or after last+1, modulo N; -1 when none.
    function automatic int model_winner(input logic [N-1:0] r);
        for (int k = 1; k <= int'(N); k++) begin
            int m;
            m = (m_last + k) % int'(N);
            if (r[m]) return m;
        end
        return -1;
    endfunction

    function automatic logic model_oor(input logic [31:0] a);
        longint unsigned lo, hi;
        lo = 64'(BASE_ADDR_DEF);
        hi = lo + 64'(RAM_BYTES_DEF);
        return RC && ((64'(a) < lo) || (64'(a) >= hi));
    endfunction

    // Monitor: pops the response due this cycle, otherwise expects silence.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check("rsp_rvalid", 64'(bus.rvalid_o), 64'(mon_e.onehot));
            check("rsp_err", 64'(bus.err_o), mon_e.err ? 64'(mon_e.onehot) : 64'd0);
            if (!mon_e.we && !mon_e.err)
                check("rsp_rdata", 64'(bus.rdata_o), 64'(mon_e.rdata));
        end else begin
            check("idle_rvalid", 64'(bus.rvalid_o), 64'd0);
            check("idle_err", 64'(bus.err_o), 64'd0);
        end
    end

    // One bus cycle: drive, then check grant/RAM pins and queue the response.
    task automatic do_cycle(input logic [N-1:0] r, input int dir_gnt,
                            input logic dir_rd_en, input logic [31:0] dir_rd);
        int           w;
        logic [N-1:0] g;
        logic         oor;
        int unsigned  wi;
        exp_t         e;
        @(posedge clk);
        #1;
        for (int m = 0; m < int'(N); m++) begin
            bus.req_i[m]   = r[m];
            bus.addr_i[m]  = stim[m].addr;
            bus.we_i[m]    = stim[m].we;
            bus.be_i[m]    = stim[m].be;
            bus.wdata_i[m] = stim[m].wdata;
        end
        @(negedge clk);
        w = model_winner(r);
        if (w < 0) begin
            check("idle_gnt", 64'(bus.gnt_o), 64'd0);
            check("idle_ram_en", 64'(ram_en), 64'd0);
            check("idle_ram_we", 64'(ram_we), 64'd0);
            check("idle_ram_be", 64'(ram_be), 64'd0);
        end else begin
            g    = '0;
            g[w] = 1'b1;
            check("gnt", 64'(bus.gnt_o), 64'(g));
            if (dir_gnt >= 0) check("dir_gnt", 64'(bus.gnt_o), 64'(1) << dir_gnt);
            oor = model_oor(stim[w].addr);
            wi  = 32'(stim[w].addr[15:2]);
            check("ram_en", 64'(ram_en), 64'(!oor));
            check("ram_we", 64'(ram_we), 64'(stim[w].we && !oor));
            check("ram_be", 64'(ram_be), 64'(stim[w].be));
            check("ram_addr", 64'(ram_addr), 64'(stim[w].addr[19:0]));
            if (stim[w].we) check("ram_wdata", 64'(ram_wdata), 64'(stim[w].wdata));
            if (stim[w].we && !oor)
                for (int b = 0; b < 4; b++)
                    if (stim[w].be[b]) ref_mem[wi][8*b +: 8] = stim[w].wdata[8*b +: 8];
            m_last   = w;
            e.due    = cyc + 1;
            e.onehot = g;
            e.we     = stim[w].we;
            e.err    = oor;
            e.rdata  = dir_rd_en ? dir_rd : ref_mem[wi];
            sb.push_back(e);
        end
    endtask

    function automatic mst_req_t rd_req(input logic [31:0] a);
        return '{addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0};
    endfunction

    initial begin
        logic [31:0] tmp;
        logic [31:0] a;
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(32'(i));
        for (int m = 0; m < int'(N); m++) stim[m] = rd_req(BASE_ADDR_DEF + 32'(4 * m));
        m_last         = int'(N) - 1;
        rst_n          = 1'b0;
        bus.req_i      = '1;
        bus.addr_i     = '0;
        bus.we_i       = '0;
        bus.be_i       = '0;
        bus.wdata_i    = '0;

        // Reset state: grant purely combinational from req, no responses.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 64'(bus.gnt_o), 64'd1);
        check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("rst_err", 64'(bus.err_o), 64'd0);
        bus.req_i = '0;
        @(negedge clk);
        check("rst_gnt_idle", 64'(bus.gnt_o), 64'd0);
        #1 rst_n = 1'b1;

        // All masters hold requests: rotation 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            for (int m = 0; m < int'(N); m++)
                stim[m] = rd_req(BASE_ADDR_DEF + 32'h40 + 32'(4 * ((k * 3 + m) % 8)));
            do_cycle('1, k % int'(N), 1'b0, 32'h0);
        end

        // Lone read by master 1.
        stim[1] = rd_req(32'h0010_0008);
        do_cycle(3'b010, 1, 1'b1, init_word(2));

        // Partial write then read-after-write by master 0.
        stim[0] = '{addr: 32'h0010_0010, we: 1'b1, be: 4'b0011, wdata: 32'hDEAD_BEEF};
        do_cycle(3'b001, 0, 1'b0, 32'h0);
        tmp     = init_word(4);
        stim[0] = rd_req(32'h0010_0010);
        do_cycle(3'b001, 0, 1'b1, {tmp[31:16], 16'hBEEF});

        // Master 1 cuts in while master 0 keeps asking; idle keeps the pointer.
        stim[0] = rd_req(BASE_ADDR_DEF + 32'h20);
        stim[1] = rd_req(BASE_ADDR_DEF + 32'h24);
        stim[2] = rd_req(BASE_ADDR_DEF + 32'h28);
        do_cycle(3'b001, 0, 1'b0, 32'h0);
        do_cycle(3'b011, 1, 1'b0, 32'h0);
        do_cycle(3'b000, -1, 1'b0, 32'h0);
        do_cycle(3'b000, -1, 1'b0, 32'h0);
        do_cycle(3'b111, 2, 1'b0, 32'h0);

        // Window edges: outside above, outside below, last word inside.
        stim[1] = rd_req(32'h0020_0000);
        do_cycle(3'b010, 1, 1'b0, 32'h0);
        stim[1] = rd_req(BASE_ADDR_DEF - 32'd4);
        do_cycle(3'b010, 1, 1'b0, 32'h0);
        stim[1] = rd_req(BASE_ADDR_DEF + RAM_BYTES_DEF - 32'd4);
        do_cycle(3'b010, 1, 1'b1, init_word(WORDS - 1));
        stim[2] = '{addr: BASE_ADDR_DEF + RAM_BYTES_DEF, we: 1'b1, be: 4'hF, wdata: 32'h1234_5678};
        do_cycle(3'b100, 2, 1'b0, 32'h0);

        // Reset while a response is in flight: it must be dropped.
        do_cycle(3'b000, -1, 1'b0, 32'h0);
        stim[2] = rd_req(BASE_ADDR_DEF + 32'h30);
        do_cycle(3'b100, 2, 1'b0, 32'h0);
        #1;
        rst_n     = 1'b0;
        bus.req_i = '0;
        sb.delete();
        m_last    = int'(N) - 1;
        @(posedge clk);
        @(negedge clk);
        check("rst_drop_rvalid", 64'(bus.rvalid_o), 64'd0);
        #1 rst_n = 1'b1;
        do_cycle('1, 0, 1'b0, 32'h0);

        // Random traffic over a small window to provoke read-after-write hits.
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, (1 << N) - 1));
            for (int m = 0; m < int'(N); m++) begin
                a = BASE_ADDR_DEF + 32'(4 * $urandom_range(0, 31));
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       a = BASE_ADDR_DEF - 32'd4;
                        1:       a = BASE_ADDR_DEF + RAM_BYTES_DEF;
                        default: a = 32'h0020_0000 + 32'(4 * $urandom_range(0, 7));
                    endcase
                end
                stim[m].addr  = a;
                stim[m].we    = ($urandom_range(0, 2) == 0);
                stim[m].be    = 4'($urandom);
                stim[m].wdata = $urandom;
            end
            do_cycle(r, -1, 1'b0, 32'h0);
        end

        for (int k = 0; k < 3; k++) do_cycle(3'b000, -1, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
        $fatal(1);
    end

endmodule : tb_sp_ram_arbiter
